rv32_alu: RTL and testbench
===========================

Name: rv32_alu

Overview:
- Registered RV32I integer ALU for the execute stage of the RISC-V core.
- Computes the eight base R/I-type operations selected by funct3, with one funct7 bit selecting SUB and SRA.
- Produces a 32-bit result and a zero flag one clock after the operands are presented.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; shift amount is in2[4:0].

Ports:
- clk     input   1      system clock; all state updates on the rising edge
- rst_n   input   1      synchronous active-low reset, sampled on rising clk
- in_valid input  1      operands and op-select valid this cycle
- in1     input   32     operand A (rs1)
- in2     input   32     operand B (rs2 or immediate)
- funct3  input   3      operation select
- funct7  input   1      instruction bit 30; alternate-op select
- out     output  32     registered result
- zero    output  1      registered flag, 1 when out == 0
- out_valid output 1     registered in_valid; qualifies out/zero

Behaviour:
- One synchronous always block on the clk rising edge. No asynchronous paths to outputs.
- Reset: when rst_n=0 at a rising edge:
  - out <= 0, zero <= 1, out_valid <= 0.
  - Reset dominates in_valid; an operation in flight is discarded.
- Latency: exactly 1 cycle. Operands sampled on edge N with in_valid=1 appear on out/zero at edge N, with out_valid=1 after edge N.
- Throughput: one operation per cycle; back-to-back in_valid is supported.
- in_valid=0: out and zero hold their previous values; out_valid <= 0.
- Operation map (funct3):
  - 000: ADD when funct7=0, in1+in2; SUB when funct7=1, in1-in2. Modulo 2^32; carry and overflow are discarded.
  - 001: SLL, in1 << in2[4:0]. funct7 ignored.
  - 010: SLT, signed two's-complement compare (in1 < in2) gives 32'd1, else 32'd0. funct7 ignored.
  - 011: SLTU, unsigned compare, same 0/1 encoding. funct7 ignored.
  - 100: XOR.
  - 101: SRL when funct7=0, logical right shift by in2[4:0]; SRA when funct7=1, arithmetic right shift by in2[4:0], replicating in1[31].
  - 110: OR.
  - 111: AND.
- Shift amount: only in2[4:0] is used; in2[31:5] are ignored. A shift amount of 0 returns in1 unchanged.
- zero is computed from the same-cycle next result and registered alongside out; it always equals (out==0).
- Operand changes between valid cycles have no effect on the outputs.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> out=0, zero=1, out_valid=0. Release rst_n; the first valid op appears 1 cycle later.
- Add/sub, in1=0x00000AC3, in2=0x0000011F:
  - funct3=000, funct7=0 -> out=0x00000BE2.
  - funct7=1 -> out=0x000009A4.
  - SUB with in1=in2=0x1234 -> out=0, zero=1.
- Logic ops, same operands:
  - XOR -> 0x00000BDC.
  - OR -> 0x00000BDF.
  - AND -> 0x00000003.
  - All with zero=0.
- Compares:
  - in1=0xC0000027, in2=0x000000F6: SLT -> 1, SLTU -> 0.
  - in1=0x000000AD, in2=0xE00000A5: SLT -> 0, SLTU -> 1.
- Shifts, in1=0xA1000015:
  - in2=2: SLL -> 0x84000054, SRL -> 0x28400005, SRA -> 0xE8400005.
  - in2=0xA: SRA -> 0xFFE84000.
  - in2=0x22: behaves as shift by 2.
- Pipeline/hold:
  - Back-to-back valid ops -> results appear on consecutive cycles in order.
  - in_valid=0 with changing operands -> out/zero hold and out_valid=0.
  - rst_n asserted while in_valid=1 -> the in-flight result is discarded.

Source files
------------

// File: rtl/rv32_alu.sv
// ----------------------------------------------------------------------------
// rv32_alu -- registered RV32I integer ALU for the execute stage.
//
// Evaluates one of the eight base R/I-type operations selected by funct3,
// with funct7 (instruction bit 30) choosing SUB over ADD and SRA over SRL.
// The result and its zero flag are registered and appear one clock after the
// operands are presented with in_valid high.
//
// Ports:
//   clk       in   1      system clock, rising edge
//   rst_n     in   1      synchronous active-low reset
//   in_valid  in   1      operands / op-select valid this cycle
//   in1       in   XLEN   operand A (rs1)
//   in2       in   XLEN   operand B (rs2 or immediate)
//   funct3    in   3      operation select
//   funct7    in   1      alternate-op select (SUB / SRA)
//   out       out  XLEN   registered result
//   zero      out  1      registered flag, 1 when out == 0
//   out_valid out  1      registered in_valid, qualifies out/zero
// ----------------------------------------------------------------------------
module rv32_alu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic            out_valid
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SLL  = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_SLTU = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SR   = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    logic [XLEN-1:0] r_out;
    logic            r_zero;
    logic            r_valid;

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_sum;
    logic [XLEN-1:0] w_diff;
    logic [XLEN-1:0] w_sll;
    logic [XLEN-1:0] w_srl;
    logic [XLEN-1:0] w_sra;
    logic            w_lt_signed;
    logic            w_lt_unsigned;
    logic [XLEN-1:0] w_result;

    // Only the low five bits of operand B form the shift amount; the rest
    // of in2 is deliberately ignored for shifts.
    assign w_shamt       = in2[4:0];
    assign w_sum         = in1 + in2;
    assign w_diff        = in1 - in2;
    assign w_sll         = in1 << w_shamt;
    assign w_srl         = in1 >> w_shamt;
    assign w_sra         = $signed(in1) >>> w_shamt;
    assign w_lt_signed   = $signed(in1) < $signed(in2);
    assign w_lt_unsigned = in1 < in2;

    always_comb begin
        w_result = '0;
        unique case (funct3)
            OP_ADD:  w_result = funct7 ? w_diff : w_sum;
            OP_SLL:  w_result = w_sll;
            OP_SLT:  w_result = {{(XLEN-1){1'b0}}, w_lt_signed};
            OP_SLTU: w_result = {{(XLEN-1){1'b0}}, w_lt_unsigned};
            OP_XOR:  w_result = in1 ^ in2;
            OP_SR:   w_result = funct7 ? w_sra : w_srl;
            OP_OR:   w_result = in1 | in2;
            OP_AND:  w_result = in1 & in2;
            default: w_result = '0;
        endcase
    end

    // Reset wins over in_valid so an op presented during reset is dropped.
    // With no valid op the result and flag keep their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out   <= '0;
            r_zero  <= 1'b1;
            r_valid <= 1'b0;
        end else if (in_valid) begin
            r_out   <= w_result;
            r_zero  <= (w_result == '0);
            r_valid <= 1'b1;
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign out       = r_out;
    assign zero      = r_zero;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_rv32_alu.sv
// ----------------------------------------------------------------------------
// tb_rv32_alu -- directed-vector bench for rv32_alu. The driver pushes the
// hand-computed result of each issued op into a queue; a monitor pops and
// compares whenever out_valid is high, checks that out/zero hold while it is
// low, and checks the reset values after any edge sampled with rst_n low.
// ----------------------------------------------------------------------------
module tb_rv32_alu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] out;
    logic        zero;
    logic        out_valid;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] exp_q[$];          // {expected zero, expected out}
    logic [31:0] hold_out  = '0;
    logic        hold_zero = 1'b1;
    logic        started   = 1'b0;
    logic        rst_seen  = 1'b1;

    rv32_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in1       (in1),
        .in2       (in2),
        .funct3    (funct3),
        .funct7    (funct7),
        .out       (out),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Capture the reset level the DUT sampled on this edge.
    always @(posedge clk) begin
        rst_seen = rst_n;
        started  = 1'b1;
    end

    // Monitor: compare mid-cycle, away from the active edge.
    always @(negedge clk) begin
        logic [32:0] e;
        if (started) begin
            if (!rst_seen) begin
                vectors++;
                hold_out  = '0;
                hold_zero = 1'b1;
                if (out !== 32'h0 || zero !== 1'b1 || out_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset: out=%08h zero=%b vld=%b required out=00000000 zero=1 vld=0",
                             out, zero, out_valid);
                end else
                    $display("reset   : out=%08h zero=%b vld=%b", out, zero, out_valid);
            end else if (out_valid === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid: out=%08h zero=%b required no output", out, zero);
                end else begin
                    e = exp_q.pop_front();
                    hold_out  = e[31:0];
                    hold_zero = e[32];
                    if (out !== e[31:0] || zero !== e[32]) begin
                        miscompares++;
                        $display("FAIL result: out=%08h zero=%b required out=%08h zero=%b",
                                 out, zero, e[31:0], e[32]);
                    end else
                        $display("result  : out=%08h zero=%b", out, zero);
                end
            end else begin
                vectors++;
                if (out_valid !== 1'b0 || out !== hold_out || zero !== hold_zero) begin
                    miscompares++;
                    $display("FAIL hold: out=%08h zero=%b vld=%b required out=%08h zero=%b vld=0",
                             out, zero, out_valid, hold_out, hold_zero);
                end else
                    $display("hold    : out=%08h zero=%b", out, zero);
            end
        end
    end

    task automatic op(input logic [2:0] f3, input logic f7,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_out);
        in_valid = 1'b1;
        funct3   = f3;
        funct7   = f7;
        in1      = a;
        in2      = b;
        if (rst_n) exp_q.push_back({(exp_out == 32'h0), exp_out});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in1      = $urandom;
            in2      = $urandom;
            funct3   = 3'($urandom_range(0, 7));
            funct7   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset held for two edges with a valid op present.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in1      = 32'h0000_0AC3;
        in2      = 32'h0000_011F;
        funct3   = 3'b000;
        funct7   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Add/sub and logic ops
        op(3'b000, 1'b0, 32'h0000_0AC3, 32'h0000_011F, 32'h0000_0BE2);
        op(3'b000, 1'b1, 32'h0000_0AC3, 32'h0000_011F, 32'h0000_09A4);
        op(3'b000, 1'b1, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000);
        op(3'b100, 1'b0, 32'h0000_0AC3, 32'h0000_011F, 32'h0000_0BDC);
        op(3'b110, 1'b0, 32'h0000_0AC3, 32'h0000_011F, 32'h0000_0BDF);
        op(3'b111, 1'b0, 32'h0000_0AC3, 32'h0000_011F, 32'h0000_0003);
        op(3'b000, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        // Compares
        op(3'b010, 1'b0, 32'hC000_0027, 32'h0000_00F6, 32'h0000_0001);
        op(3'b011, 1'b0, 32'hC000_0027, 32'h0000_00F6, 32'h0000_0000);
        op(3'b010, 1'b1, 32'h0000_00AD, 32'hE000_00A5, 32'h0000_0000);
        op(3'b011, 1'b1, 32'h0000_00AD, 32'hE000_00A5, 32'h0000_0001);
        op(3'b010, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000);
        // Shifts
        op(3'b001, 1'b0, 32'hA100_0015, 32'h0000_0002, 32'h8400_0054);
        op(3'b101, 1'b0, 32'hA100_0015, 32'h0000_0002, 32'h2840_0005);
        op(3'b101, 1'b1, 32'hA100_0015, 32'h0000_0002, 32'hE840_0005);
        op(3'b101, 1'b1, 32'hA100_0015, 32'h0000_000A, 32'hFFE8_4000);
        op(3'b001, 1'b1, 32'hA100_0015, 32'h0000_0022, 32'h8400_0054);
        op(3'b101, 1'b0, 32'hA100_0015, 32'h0000_0022, 32'h2840_0005);
        op(3'b101, 1'b1, 32'hA100_0015, 32'h0000_0022, 32'hE840_0005);
        op(3'b001, 1'b0, 32'hA100_0015, 32'hFFFF_FFE0, 32'hA100_0015);
        op(3'b101, 1'b0, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001);
        op(3'b101, 1'b1, 32'h8000_0000, 32'h0000_001F, 32'hFFFF_FFFF);

        // Hold with changing operands
        idle(3);
        op(3'b110, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
        idle(2);
        op(3'b100, 1'b0, 32'h5555_0000, 32'h0000_AAAA, 32'h5555_AAAA);
        idle(2);

        // Reset asserted while an op is presented: the op is discarded.
        rst_n = 1'b0;
        op(3'b000, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
        rst_n = 1'b1;
        idle(1);
        op(3'b000, 1'b0, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);
        idle(3);

        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
